kse_jtag_req_responder: RTL and testbench



---
 rtl/kse_jtag_req_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_kse_jtag_req_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kse_jtag_req_responder.sv
// Responder end of the KSE3 JTAG TDR request/response channel.
// Takes one request per valid/ready handshake, runs a single-word AHB-Lite
// transfer or a KSE3 command, returns a response and tracks JTAG access mode.

package kse3_jtag_pkg;
  typedef struct packed {
    logic        ahb_valid;
    logic        enter_jtag_access_mode;
    logic        init_kse3_adac_itf;
    logic        ahb_hwrite;
    logic [31:0] ahb_haddr;
    logic [31:0] ahb_hwdata;
  } kse3_jtag_req_t;

  typedef struct packed {
    logic [31:0] ahb_hrdata;
    logic        ahb_error;
    logic        kse_error;
    logic        cmd_ignored;
  } kse3_jtag_resp_t;
endpackage

// Handshake: a request is taken in IDLE when i_tdr_valid is high. The
// response is offered with o_tdr_ready high in RESP and the transaction
// completes on the cycle where i_tdr_valid & o_tdr_ready are both high;
// valid seen in any other state is ignored.
module kse_jtag_req_responder
  import kse3_jtag_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_tdr_valid,
  input  kse3_jtag_req_t  i_kse3_jtag_req,
  output logic            o_tdr_ready,
  output kse3_jtag_resp_t o_kse3_jtag_resp,
  output logic            o_kse_cmd_valid,
  output logic            o_kse_cmd_init,
  input  logic            i_kse_cmd_done,
  input  logic            i_kse_cmd_error,
  input  logic            i_jtag_lock,
  output logic            o_jtag_access_mode,
  output logic [31:0]     o_haddr,
  output logic [1:0]      o_htrans,
  output logic            o_hwrite,
  output logic [2:0]      o_hsize,
  output logic [31:0]     o_hwdata,
  input  logic            i_hready,
  input  logic            i_hresp,
  input  logic [31:0]     i_hrdata
);

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KSE_CMD  = 3'd1,
    ST_AHB_ADDR = 3'd2,
    ST_AHB_DATA = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  kse3_jtag_resp_t resp_q, resp_d;
  logic            ready_q, ready_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            cmd_init_q, cmd_init_d;
  logic            access_q, access_d;
  logic [1:0]      htrans_q, htrans_d;
  logic [31:0]     haddr_q, haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]      cmd_bits;
  logic            cmd_onehot;
  logic            req_ignored;
  logic            timeout_hit;
  logic [CntW-1:0] cnt_inc;

  // Request classification and timeout detection.
  always_comb begin
    cmd_bits    = {i_kse3_jtag_req.ahb_valid,
                   i_kse3_jtag_req.enter_jtag_access_mode,
                   i_kse3_jtag_req.init_kse3_adac_itf};
    cmd_onehot  = (cmd_bits == 3'b100) || (cmd_bits == 3'b010) || (cmd_bits == 3'b001);
    req_ignored = !cmd_onehot || i_jtag_lock ||
                  (i_kse3_jtag_req.ahb_valid && !access_q) ||
                  (i_kse3_jtag_req.ahb_valid && (i_kse3_jtag_req.ahb_haddr[1:0] != 2'b00));
    timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntMax);
    cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    ready_d     = ready_q;
    cmd_valid_d = cmd_valid_q;
    cmd_init_d  = cmd_init_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    access_d    = access_q;

    case (state_q)
      ST_IDLE: begin
        if (i_tdr_valid) begin
          if (req_ignored) begin
            resp_d.cmd_ignored = 1'b1;
            ready_d            = 1'b1;
            state_d            = ST_RESP;
          end else if (i_kse3_jtag_req.ahb_valid) begin
            htrans_d = HtransNonseq;
            haddr_d  = i_kse3_jtag_req.ahb_haddr;
            hwrite_d = i_kse3_jtag_req.ahb_hwrite;
            wdata_d  = i_kse3_jtag_req.ahb_hwdata;
            cnt_d    = '0;
            state_d  = ST_AHB_ADDR;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_init_d  = i_kse3_jtag_req.init_kse3_adac_itf;
            state_d     = ST_KSE_CMD;
          end
        end
      end

      ST_KSE_CMD: begin
        if (i_kse_cmd_done) begin
          cmd_valid_d      = 1'b0;
          cmd_init_d       = 1'b0;
          resp_d.kse_error = i_kse_cmd_error;
          ready_d          = 1'b1;
          state_d          = ST_RESP;
        end
      end

      ST_AHB_ADDR: begin
        if (i_hready) begin
          htrans_d = HtransIdle;
          hwdata_d = hwrite_q ? wdata_q : 32'h0;
          cnt_d    = cnt_inc;
          state_d  = ST_AHB_DATA;
        end else if (timeout_hit) begin
          htrans_d         = HtransIdle;
          resp_d.ahb_error = 1'b1;
          ready_d          = 1'b1;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_AHB_DATA: begin
        if (i_hready) begin
          resp_d.ahb_hrdata = hwrite_q ? 32'h0 : i_hrdata;
          resp_d.ahb_error  = i_hresp;
          hwdata_d          = 32'h0;
          ready_d           = 1'b1;
          state_d           = ST_RESP;
        end else if (timeout_hit) begin
          resp_d.ahb_error = 1'b1;
          hwdata_d         = 32'h0;
          ready_d          = 1'b1;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        // Response held until the upstream side takes it; cleared on exit.
        if (i_tdr_valid) begin
          ready_d = 1'b0;
          resp_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        ready_d     = 1'b0;
        resp_d      = '0;
        cmd_valid_d = 1'b0;
        htrans_d    = HtransIdle;
        state_d     = ST_IDLE;
      end
    endcase

    // Lock wins over a successful enter completing in the same cycle.
    if (i_jtag_lock) begin
      access_d = 1'b0;
    end else if ((state_q == ST_KSE_CMD) && i_kse_cmd_done &&
                 !i_kse_cmd_error && !cmd_init_q) begin
      access_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      resp_q      <= '0;
      ready_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_init_q  <= 1'b0;
      access_q    <= 1'b0;
      htrans_q    <= HtransIdle;
      haddr_q     <= 32'h0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= 32'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      ready_q     <= ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_init_q  <= cmd_init_d;
      access_q    <= access_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_tdr_ready        = ready_q;
  assign o_kse3_jtag_resp   = resp_q;
  assign o_kse_cmd_valid    = cmd_valid_q;
  assign o_kse_cmd_init     = cmd_init_q;
  assign o_jtag_access_mode = access_q;
  assign o_htrans           = htrans_q;
  assign o_haddr            = haddr_q;
  assign o_hwrite           = hwrite_q;
  assign o_hsize            = 3'b010;
  assign o_hwdata           = hwdata_q;

endmodule

// File: tb/tb_kse_jtag_req_responder.sv
// Bench for kse_jtag_req_responder: a vector table for classification and
// end-to-end responses, plus hand-timed sequences for latency corners.
module tb_kse_jtag_req_responder;
  import kse3_jtag_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            tdr_valid;
  kse3_jtag_req_t  req;
  logic            tdr_ready;
  kse3_jtag_resp_t resp;
  logic            kse_cmd_valid;
  logic            kse_cmd_init;
  logic            kse_done;
  logic            kse_err;
  logic            jtag_lock;
  logic            access_mode;
  logic [31:0]     haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [31:0]     hwdata;
  logic            hready;
  logic            hresp;
  logic [31:0]     hrdata;

  int tests_run;
  int tests_failed;

  kse_jtag_req_responder #(.TimeoutCycles(8)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_tdr_valid        (tdr_valid),
    .i_kse3_jtag_req    (req),
    .o_tdr_ready        (tdr_ready),
    .o_kse3_jtag_resp   (resp),
    .o_kse_cmd_valid    (kse_cmd_valid),
    .o_kse_cmd_init     (kse_cmd_init),
    .i_kse_cmd_done     (kse_done),
    .i_kse_cmd_error    (kse_err),
    .i_jtag_lock        (jtag_lock),
    .o_jtag_access_mode (access_mode),
    .o_haddr            (haddr),
    .o_htrans           (htrans),
    .o_hwrite           (hwrite),
    .o_hsize            (hsize),
    .o_hwdata           (hwdata),
    .i_hready           (hready),
    .i_hresp            (hresp),
    .i_hrdata           (hrdata)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        ahb;
    logic        enter;
    logic        init;
    logic        hwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        lock;
    logic        kerr;
    logic        exp_ready1;
    logic [1:0]  exp_htrans1;
    logic        exp_cmd_valid1;
    logic        exp_cmd_init1;
    logic [31:0] exp_rdata;
    logic        exp_ignored;
    logic        exp_mode;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic ahb, input logic enter, input logic init,
                      input logic hwr, input logic [31:0] addr, input logic [31:0] wdata);
    req.ahb_valid              = ahb;
    req.enter_jtag_access_mode = enter;
    req.init_kse3_adac_itf     = init;
    req.ahb_hwrite             = hwr;
    req.ahb_haddr              = addr;
    req.ahb_hwdata             = wdata;
    tdr_valid                  = 1'b1;
  endtask

  function automatic logic [63:0] rsp(input logic [31:0] rd, input logic aerr,
                                      input logic kerr, input logic ign);
    kse3_jtag_resp_t r;
    r.ahb_hrdata  = rd;
    r.ahb_error   = aerr;
    r.kse_error   = kerr;
    r.cmd_ignored = ign;
    return 64'(r);
  endfunction

  // Completes the handshake: valid is high while ready is seen, then drop it.
  task automatic take_resp(input string name);
    step();
    tdr_valid = 1'b0;
    chk({name, ":ready_after_hs"}, 64'(tdr_ready), 64'(0));
    chk({name, ":resp_cleared"}, 64'(resp), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    send(v.ahb, v.enter, v.init, v.hwr, v.addr, v.wdata);
    jtag_lock = v.lock;
    hrdata    = v.rdata;
    hready    = 1'b1;
    hresp     = 1'b0;
    step();
    jtag_lock = 1'b0;
    chk({v.name, ":ready_n1"}, 64'(tdr_ready), 64'(v.exp_ready1));
    chk({v.name, ":htrans_n1"}, 64'(htrans), 64'(v.exp_htrans1));
    chk({v.name, ":cmd_valid_n1"}, 64'(kse_cmd_valid), 64'(v.exp_cmd_valid1));
    chk({v.name, ":cmd_init_n1"}, 64'(kse_cmd_init), 64'(v.exp_cmd_init1));
    if (v.exp_cmd_valid1) begin
      step();
      kse_done = 1'b1;
      kse_err  = v.kerr;
      step();
      kse_done = 1'b0;
      kse_err  = 1'b0;
    end
    w = 0;
    while (!tdr_ready && w < 20) begin
      step();
      w++;
    end
    chk({v.name, ":ready"}, 64'(tdr_ready), 64'(1));
    chk({v.name, ":resp"}, 64'(resp), rsp(v.exp_rdata, 1'b0, v.kerr, v.exp_ignored));
    chk({v.name, ":mode"}, 64'(access_mode), 64'(v.exp_mode));
    take_resp(v.name);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    tdr_valid    = 1'b0;
    req          = '0;
    kse_done     = 1'b0;
    kse_err      = 1'b0;
    jtag_lock    = 1'b0;
    hready       = 1'b1;
    hresp        = 1'b0;
    hrdata       = 32'h0;

    //          name              ahb en in wr addr          wdata         rdata         lk ke r1 ht    cv ci exp_rdata     ig md
    vecs[0]  = '{"ahb_no_mode",    1, 0, 0, 0, 32'h20000010, 32'h0,        32'h11111111, 0, 0, 1, 2'b00, 0, 0, 32'h0,        1, 0};
    vecs[1]  = '{"two_bits",       0, 1, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1, 2'b00, 0, 0, 32'h0,        1, 0};
    vecs[2]  = '{"zero_bits",      0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1, 2'b00, 0, 0, 32'h0,        1, 0};
    vecs[3]  = '{"init",           0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 1, 1, 32'h0,        0, 0};
    vecs[4]  = '{"init_err",       0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 1, 1, 32'h0,        0, 0};
    vecs[5]  = '{"enter_locked",   0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1, 2'b00, 0, 0, 32'h0,        1, 0};
    vecs[6]  = '{"enter_err",      0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0, 2'b00, 1, 0, 32'h0,        0, 0};
    vecs[7]  = '{"enter",          0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 1, 0, 32'h0,        0, 1};
    vecs[8]  = '{"ahb_misaligned", 1, 0, 0, 0, 32'h20000012, 32'h0,        32'h22222222, 0, 0, 1, 2'b00, 0, 0, 32'h0,        1, 1};
    vecs[9]  = '{"ahb_read",       1, 0, 0, 0, 32'h20000010, 32'h0,        32'hDEADBEEF, 0, 0, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 1};
    vecs[10] = '{"ahb_write",      1, 0, 0, 1, 32'h20000004, 32'h12345678, 32'hCAFEF00D, 0, 0, 0, 2'b10, 0, 0, 32'h0,        0, 1};
    vecs[11] = '{"ahb_locked",     1, 0, 0, 0, 32'h20000010, 32'h0,        32'h33333333, 1, 0, 1, 2'b00, 0, 0, 32'h0,        1, 0};

    // Reset values.
    step();
    step();
    chk("rst:ready", 64'(tdr_ready), 64'(0));
    chk("rst:resp", 64'(resp), 64'(0));
    chk("rst:cmd_valid", 64'(kse_cmd_valid), 64'(0));
    chk("rst:cmd_init", 64'(kse_cmd_init), 64'(0));
    chk("rst:mode", 64'(access_mode), 64'(0));
    chk("rst:htrans", 64'(htrans), 64'(0));
    chk("rst:haddr", 64'(haddr), 64'(0));
    chk("rst:hwrite", 64'(hwrite), 64'(0));
    chk("rst:hsize", 64'(hsize), 64'(3'b010));
    chk("rst:hwdata", 64'(hwdata), 64'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Enter with done three cycles after the request: ready at N+4.
    send(0, 1, 0, 0, 32'h0, 32'h0);
    step();
    chk("enter_t:cmd_valid_n1", 64'(kse_cmd_valid), 64'(1));
    chk("enter_t:cmd_init_n1", 64'(kse_cmd_init), 64'(0));
    step();
    chk("enter_t:cmd_valid_n2", 64'(kse_cmd_valid), 64'(1));
    step();
    kse_done = 1'b1;
    chk("enter_t:ready_n3", 64'(tdr_ready), 64'(0));
    step();
    kse_done = 1'b0;
    chk("enter_t:ready_n4", 64'(tdr_ready), 64'(1));
    chk("enter_t:resp", 64'(resp), 64'(0));
    chk("enter_t:mode", 64'(access_mode), 64'(1));
    chk("enter_t:cmd_valid_n4", 64'(kse_cmd_valid), 64'(0));
    take_resp("enter_t");

    // Zero-wait read: address N+1, data N+2, ready N+3.
    hrdata = 32'hDEADBEEF;
    hready = 1'b1;
    send(1, 0, 0, 0, 32'h20000010, 32'h0);
    step();
    chk("rd0:htrans_n1", 64'(htrans), 64'(2'b10));
    chk("rd0:haddr_n1", 64'(haddr), 64'(32'h20000010));
    chk("rd0:hwrite_n1", 64'(hwrite), 64'(0));
    chk("rd0:hsize_n1", 64'(hsize), 64'(3'b010));
    step();
    chk("rd0:htrans_n2", 64'(htrans), 64'(2'b00));
    chk("rd0:ready_n2", 64'(tdr_ready), 64'(0));
    step();
    chk("rd0:ready_n3", 64'(tdr_ready), 64'(1));
    chk("rd0:resp", 64'(resp), rsp(32'hDEADBEEF, 0, 0, 0));
    take_resp("rd0");

    // Write, two data-phase wait states, error response: ready at N+5.
    send(1, 0, 0, 1, 32'h20000004, 32'h5A5A1234);
    step();
    chk("wr2:htrans_n1", 64'(htrans), 64'(2'b10));
    chk("wr2:hwrite_n1", 64'(hwrite), 64'(1));
    chk("wr2:haddr_n1", 64'(haddr), 64'(32'h20000004));
    step();
    chk("wr2:htrans_n2", 64'(htrans), 64'(2'b00));
    chk("wr2:hwdata_n2", 64'(hwdata), 64'(32'h5A5A1234));
    hready = 1'b0;
    step();
    chk("wr2:ready_n3", 64'(tdr_ready), 64'(0));
    chk("wr2:hwdata_n3", 64'(hwdata), 64'(32'h5A5A1234));
    step();
    chk("wr2:ready_n4", 64'(tdr_ready), 64'(0));
    hready = 1'b1;
    hresp  = 1'b1;
    step();
    hresp = 1'b0;
    chk("wr2:ready_n5", 64'(tdr_ready), 64'(1));
    chk("wr2:resp", 64'(resp), rsp(32'h0, 1, 0, 0));
    take_resp("wr2");

    // Timeout with hready stuck low: ready 9 cycles after AHB_ADDR entry.
    hready = 1'b0;
    hrdata = 32'h44444444;
    send(1, 0, 0, 0, 32'h20000020, 32'h0);
    step();
    chk("tmo:htrans_n1", 64'(htrans), 64'(2'b10));
    for (int k = 2; k <= 9; k++) step();
    chk("tmo:ready_n9", 64'(tdr_ready), 64'(0));
    chk("tmo:htrans_n9", 64'(htrans), 64'(2'b10));
    step();
    chk("tmo:ready_n10", 64'(tdr_ready), 64'(1));
    chk("tmo:resp", 64'(resp), rsp(32'h0, 1, 0, 0));
    chk("tmo:htrans_n10", 64'(htrans), 64'(2'b00));
    hready = 1'b1;
    take_resp("tmo");

    // Next request accepted; valid dropped for 5 cycles during RESP.
    hrdata = 32'hA5A55A5A;
    send(1, 0, 0, 0, 32'h20000030, 32'h0);
    step();
    tdr_valid = 1'b0;
    chk("hold:htrans_n1", 64'(htrans), 64'(2'b10));
    step();
    step();
    hrdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("hold:ready", 64'(tdr_ready), 64'(1));
      chk("hold:resp", 64'(resp), rsp(32'hA5A55A5A, 0, 0, 0));
      step();
    end
    chk("hold:ready_last", 64'(tdr_ready), 64'(1));
    tdr_valid = 1'b1;
    step();
    tdr_valid = 1'b0;
    chk("hold:ready_exit", 64'(tdr_ready), 64'(0));
    chk("hold:resp_exit", 64'(resp), 64'(0));

    // Lock mid-transfer: transfer completes, access mode clears.
    hready = 1'b0;
    hrdata = 32'h0BADF00D;
    send(1, 0, 0, 0, 32'h20000040, 32'h0);
    step();
    jtag_lock = 1'b1;
    chk("lock:mode_n1", 64'(access_mode), 64'(1));
    step();
    jtag_lock = 1'b0;
    chk("lock:mode_n2", 64'(access_mode), 64'(0));
    chk("lock:htrans_n2", 64'(htrans), 64'(2'b10));
    hready = 1'b1;
    step();
    chk("lock:htrans_n3", 64'(htrans), 64'(2'b00));
    step();
    chk("lock:ready_n4", 64'(tdr_ready), 64'(1));
    chk("lock:resp", 64'(resp), rsp(32'h0BADF00D, 0, 0, 0));
    chk("lock:mode_n4", 64'(access_mode), 64'(0));
    take_resp("lock");
    send(1, 0, 0, 0, 32'h20000010, 32'h0);
    step();
    chk("lock:ign_ready", 64'(tdr_ready), 64'(1));
    chk("lock:ign_resp", 64'(resp), rsp(32'h0, 0, 0, 1));
    chk("lock:ign_htrans", 64'(htrans), 64'(2'b00));
    take_resp("lock_ign");

    // Lock in the same cycle as a successful enter completion wins.
    send(0, 1, 0, 0, 32'h0, 32'h0);
    step();
    kse_done  = 1'b1;
    jtag_lock = 1'b1;
    step();
    kse_done  = 1'b0;
    jtag_lock = 1'b0;
    chk("lock_prio:ready", 64'(tdr_ready), 64'(1));
    chk("lock_prio:resp", 64'(resp), 64'(0));
    chk("lock_prio:mode", 64'(access_mode), 64'(0));
    take_resp("lock_prio");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
